// File: rtl/image_mem_scheduler_if.sv
// ---------------------------------------------------------------------------
// image_mem_scheduler_if
// Bundles every non-clock signal of the image memory scheduler:
//   control : clear_start (in), busy, clear_done, addr_err (out)
//   draw    : draw_req/draw_addr/draw_data (in), draw_ack (out)
//   nn      : nn_req/nn_addr/nn_lock (in), nn_ack/nn_rdata/nn_rvalid (out)
//   memory  : mem_addr/mem_wdata/mem_we (out), mem_rdata (in)
// Modport "slave" is the scheduler's view; "master" is the view of the
// surrounding logic (drawing grid, NN reader and the image memory itself).
// ---------------------------------------------------------------------------
interface image_mem_scheduler_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32
);
   logic                     clear_start;
   logic                     busy;
   logic                     clear_done;
   logic                     addr_err;

   logic                     draw_req;
   logic [ADDR_W-1:0]        draw_addr;
   logic signed [DATA_W-1:0] draw_data;
   logic                     draw_ack;

   logic                     nn_req;
   logic [ADDR_W-1:0]        nn_addr;
   logic                     nn_ack;
   logic                     nn_lock;
   logic signed [DATA_W-1:0] nn_rdata;
   logic                     nn_rvalid;

   logic [ADDR_W-1:0]        mem_addr;
   logic signed [DATA_W-1:0] mem_wdata;
   logic                     mem_we;
   logic signed [DATA_W-1:0] mem_rdata;

   modport slave (
      input  clear_start, draw_req, draw_addr, draw_data,
             nn_req, nn_addr, nn_lock, mem_rdata,
      output busy, clear_done, addr_err, draw_ack, nn_ack,
             nn_rdata, nn_rvalid, mem_addr, mem_wdata, mem_we
   );

   modport master (
      output clear_start, draw_req, draw_addr, draw_data,
             nn_req, nn_addr, nn_lock, mem_rdata,
      input  busy, clear_done, addr_err, draw_ack, nn_ack,
             nn_rdata, nn_rvalid, mem_addr, mem_wdata, mem_we
   );
endinterface

// File: rtl/image_mem_scheduler.sv
// ---------------------------------------------------------------------------
// image_mem_scheduler
// Shares the single port of the 28x28 image memory between the drawing grid
// (writes), the NN input reader (reads) and an internal clear engine that
// zeroes the whole frame.
// Ports:
//   CLOCK_50 : sole clock, rising edge
//   reset    : synchronous, active-high
//   bus      : image_mem_scheduler_if.slave (draw / nn / memory / control)
// Draw and NN are round-robined; nn_lock masks draw; clear preempts both.
// Draw writes appear on the memory port one cycle after the handshake; NN
// read data returns three cycles after the handshake.
// ---------------------------------------------------------------------------
module image_mem_scheduler #(
   parameter int GRID_SIZE = 28,
   parameter int ADDR_W    = 16,
   parameter int DATA_W    = 32
) (
   input  logic                  CLOCK_50,
   input  logic                  reset,
   image_mem_scheduler_if.slave  bus
);
   localparam int NUM_PIX = GRID_SIZE * GRID_SIZE;
   localparam int CNT_W   = 10;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(NUM_PIX - 1);
   localparam logic [ADDR_W-1:0] ADDR_LIM = ADDR_W'(NUM_PIX);

   typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DONE} state_t;

   state_t                   r_state;
   state_t                   w_next;
   logic                     r_last_nn;      // 0: draw granted last, 1: NN
   logic [CNT_W-1:0]         r_cnt;
   logic [CNT_W-1:0]         w_cnt_nxt;
   logic                     w_draw_gnt;
   logic                     w_nn_gnt;
   logic                     w_clr_go;
   logic                     w_draw_ok;
   logic                     w_nn_ok;

   logic                     r_rd_vld_p0;
   logic                     r_rd_oor_p0;
   logic                     r_rd_vld_p1;
   logic                     r_rd_oor_p1;

   logic [ADDR_W-1:0]        r_mem_addr;
   logic signed [DATA_W-1:0] r_mem_wdata;
   logic                     r_mem_we;
   logic signed [DATA_W-1:0] r_nn_rdata;
   logic                     r_nn_rvalid;
   logic                     r_addr_err;

   assign w_draw_ok = (bus.draw_addr < ADDR_LIM);
   assign w_nn_ok   = (bus.nn_addr < ADDR_LIM);
   assign w_cnt_nxt = r_cnt + CNT_W'(1);

   always_ff @(posedge CLOCK_50) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      w_draw_gnt = 1'b0;
      w_nn_gnt   = 1'b0;
      w_clr_go   = 1'b0;
      case (r_state)
         S_IDLE: begin
            // A clear request wins the cycle outright: no ack is issued.
            if (bus.clear_start) begin
               w_clr_go = 1'b1;
               w_next   = S_CLEAR;
            end else if (bus.nn_req && bus.draw_req && !bus.nn_lock) begin
               if (r_last_nn) w_draw_gnt = 1'b1;
               else           w_nn_gnt   = 1'b1;
            end else begin
               w_nn_gnt   = bus.nn_req;
               w_draw_gnt = bus.draw_req && !bus.nn_lock;
            end
         end
         S_CLEAR: if (r_cnt == CNT_LAST) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_last_nn   <= 1'b0;
         r_cnt       <= '0;
         r_rd_vld_p0 <= 1'b0;
         r_rd_oor_p0 <= 1'b0;
         r_rd_vld_p1 <= 1'b0;
         r_rd_oor_p1 <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_mem_we    <= 1'b0;
         r_nn_rdata  <= '0;
         r_nn_rvalid <= 1'b0;
         r_addr_err  <= 1'b0;
      end else begin
         r_mem_we   <= 1'b0;
         r_addr_err <= 1'b0;

         if (w_draw_gnt)    r_last_nn <= 1'b0;
         else if (w_nn_gnt) r_last_nn <= 1'b1;

         // p0: read address on the memory port
         r_rd_vld_p0 <= w_nn_gnt;
         r_rd_oor_p0 <= w_nn_gnt && !w_nn_ok;
         // p1: memory presents read data
         r_rd_vld_p1 <= r_rd_vld_p0;
         r_rd_oor_p1 <= r_rd_oor_p0;
         // p2: registered NN result; out-of-range reads return zero
         r_nn_rvalid <= r_rd_vld_p1;
         if (r_rd_vld_p1) r_nn_rdata <= r_rd_oor_p1 ? '0 : bus.mem_rdata;

         if (w_clr_go) begin
            r_cnt       <= '0;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
         end else if (r_state == S_CLEAR) begin
            // r_cnt tracks the address currently on the port.
            if (r_cnt == CNT_LAST) begin
               r_cnt <= '0;
            end else begin
               r_cnt       <= w_cnt_nxt;
               r_mem_we    <= 1'b1;
               r_mem_addr  <= ADDR_W'(w_cnt_nxt);
               r_mem_wdata <= '0;
            end
         end else if (w_draw_gnt) begin
            if (w_draw_ok) begin
               r_mem_we    <= 1'b1;
               r_mem_addr  <= bus.draw_addr;
               r_mem_wdata <= bus.draw_data;
            end else begin
               r_addr_err <= 1'b1;
            end
         end else if (w_nn_gnt) begin
            if (w_nn_ok) r_mem_addr <= bus.nn_addr;
            else         r_addr_err <= 1'b1;
         end
      end
   end

   assign bus.draw_ack   = w_draw_gnt;
   assign bus.nn_ack     = w_nn_gnt;
   assign bus.busy       = (r_state == S_CLEAR);
   assign bus.clear_done = (r_state == S_DONE);
   assign bus.addr_err   = r_addr_err;
   assign bus.mem_addr   = r_mem_addr;
   assign bus.mem_wdata  = r_mem_wdata;
   assign bus.mem_we     = r_mem_we;
   assign bus.nn_rdata   = r_nn_rdata;
   assign bus.nn_rvalid  = r_nn_rvalid;
endmodule

// File: tb/tb_image_mem_scheduler.sv
// ---------------------------------------------------------------------------
// tb_image_mem_scheduler
// Scoreboard bench: a reference process watching the requests at each
// negedge decides which handshake should happen, pushes the expected memory
// writes, read returns and error pulses (stamped with their due cycle) into
// queues; a monitor pops and compares whenever the DUT presents an output.
// ---------------------------------------------------------------------------
module tb_image_mem_scheduler;
   localparam int NPIX = 784;

   typedef struct {
      int cyc;
      int addr;
      int data;
   } item_t;

   logic CLOCK_50 = 1'b0;
   logic reset    = 1'b1;
   int   cyc      = 0;
   int   checks   = 0;
   int   failures = 0;

   image_mem_scheduler_if #(.ADDR_W(16), .DATA_W(32)) bus ();

   image_mem_scheduler #(.GRID_SIZE(28), .ADDR_W(16), .DATA_W(32)) dut (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .bus      (bus)
   );

   always #5 CLOCK_50 = ~CLOCK_50;
   always @(posedge CLOCK_50) cyc <= cyc + 1;

   // Behavioural image memory: registered read, write on mem_we.
   logic signed [31:0] mem [0:NPIX-1];
   always @(posedge CLOCK_50) begin
      if (bus.mem_we && bus.mem_addr < 16'(NPIX)) mem[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= (bus.mem_addr < 16'(NPIX)) ? mem[bus.mem_addr] : 32'sd0;
   end

   // Reference state
   int    ref_mem [NPIX];
   item_t wq[$];
   item_t rq[$];
   int    eq[$];
   bit    ref_last_nn = 1'b0;
   int    idle_from   = 0;
   int    busy_lo     = 1;
   int    busy_hi     = 0;
   int    done_cyc    = -1;

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s cycle=%0d actual=%0d expected=%0d", nm, cyc, act, exp);
      end
   endtask

   function automatic void flush_after(input int c);
      item_t k[$];
      int    ek[$];
      foreach (wq[i]) if (wq[i].cyc <= c) k.push_back(wq[i]);
      wq = k;
      k = {};
      foreach (rq[i]) if (rq[i].cyc <= c) k.push_back(rq[i]);
      rq = k;
      foreach (eq[i]) if (eq[i] <= c) ek.push_back(eq[i]);
      eq = ek;
   endfunction

   // Reference: decide grants and queue expected responses.
   always @(negedge CLOCK_50) begin : ref_model
      bit exp_d, exp_n, ne, de, idle;
      int a;
      if (reset) begin
         ref_last_nn = 1'b0;
         idle_from   = cyc + 1;
         if (busy_hi > cyc)  busy_hi  = cyc;
         if (done_cyc > cyc) done_cyc = -1;
         flush_after(cyc);
      end else begin
         idle  = (cyc >= idle_from);
         exp_d = 1'b0;
         exp_n = 1'b0;
         if (idle && !bus.clear_start) begin
            ne = bus.nn_req;
            de = bus.draw_req && !bus.nn_lock;
            if (ne && de) begin
               exp_n = !ref_last_nn;
               exp_d = ref_last_nn;
            end else begin
               exp_n = ne;
               exp_d = de;
            end
         end
         chk("draw_ack", bus.draw_ack, exp_d);
         chk("nn_ack", bus.nn_ack, exp_n);
         if (idle && bus.clear_start) begin
            busy_lo   = cyc + 1;
            busy_hi   = cyc + NPIX;
            done_cyc  = cyc + NPIX + 1;
            idle_from = cyc + NPIX + 2;
            for (int i = 0; i < NPIX; i++) begin
               wq.push_back('{cyc + 1 + i, i, 0});
               ref_mem[i] = 0;
            end
         end
         if (exp_d) begin
            ref_last_nn = 1'b0;
            a = int'(bus.draw_addr);
            if (a < NPIX) begin
               wq.push_back('{cyc + 1, a, int'(bus.draw_data)});
               ref_mem[a] = int'(bus.draw_data);
            end else begin
               eq.push_back(cyc + 1);
            end
         end
         if (exp_n) begin
            ref_last_nn = 1'b1;
            a = int'(bus.nn_addr);
            if (a < NPIX) begin
               rq.push_back('{cyc + 3, a, ref_mem[a]});
            end else begin
               rq.push_back('{cyc + 3, a, 0});
               eq.push_back(cyc + 1);
            end
         end
      end
   end

   // Monitor: compare whatever the DUT presents against the queues.
   always @(negedge CLOCK_50) begin : monitor
      while (wq.size() > 0 && wq[0].cyc < cyc) begin
         chk("wr_missing_addr", -1, wq[0].addr);
         void'(wq.pop_front());
      end
      if (bus.mem_we) begin
         if (wq.size() == 0 || wq[0].cyc != cyc) begin
            chk("wr_unexpected_addr", int'(bus.mem_addr), -1);
         end else begin
            chk("wr_addr", int'(bus.mem_addr), wq[0].addr);
            chk("wr_data", int'(bus.mem_wdata), wq[0].data);
            void'(wq.pop_front());
         end
      end
      while (rq.size() > 0 && rq[0].cyc < cyc) begin
         chk("rd_missing_addr", -1, rq[0].addr);
         void'(rq.pop_front());
      end
      if (bus.nn_rvalid) begin
         if (rq.size() == 0 || rq[0].cyc != cyc) begin
            chk("rd_unexpected_data", int'(bus.nn_rdata), -1);
         end else begin
            chk("rd_data", int'(bus.nn_rdata), rq[0].data);
            void'(rq.pop_front());
         end
      end
      while (eq.size() > 0 && eq[0] < cyc) begin
         chk("err_missing", 0, 1);
         void'(eq.pop_front());
      end
      if (bus.addr_err) begin
         if (eq.size() == 0 || eq[0] != cyc) chk("err_unexpected", 1, 0);
         else begin
            chk("err_pulse", 1, 1);
            void'(eq.pop_front());
         end
      end
      chk("busy", bus.busy, (cyc >= busy_lo && cyc <= busy_hi));
      chk("clear_done", bus.clear_done, (cyc == done_cyc));
   end

   task automatic tick();
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic do_draw(input int a, input int d);
      bit got = 1'b0;
      tick();
      bus.draw_req  = 1'b1;
      bus.draw_addr = 16'(a);
      bus.draw_data = d;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge CLOCK_50);
         got = bus.draw_ack;
         tick();
      end
      bus.draw_req = 1'b0;
      chk("draw_handshake_done", got, 1);
   endtask

   task automatic do_nn(input int a);
      bit got = 1'b0;
      tick();
      bus.nn_req  = 1'b1;
      bus.nn_addr = 16'(a);
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge CLOCK_50);
         got = bus.nn_ack;
         tick();
      end
      bus.nn_req = 1'b0;
      chk("nn_handshake_done", got, 1);
   endtask

   function automatic int rnd_addr();
      if ($urandom_range(0, 15) == 0) return int'($urandom_range(NPIX, 65535));
      return int'($urandom_range(0, NPIX - 1));
   endfunction

   // Random traffic; requesters hold until acked. Optional clear pulse.
   task automatic rand_phase(input int n, input int clr_at);
      bit dh, nh;
      for (int i = 0; i < n; i++) begin
         @(negedge CLOCK_50);
         dh = bus.draw_req && bus.draw_ack;
         nh = bus.nn_req && bus.nn_ack;
         tick();
         if (!bus.draw_req || dh) begin
            bus.draw_req  = $urandom_range(0, 1) == 1;
            bus.draw_addr = 16'(rnd_addr());
            bus.draw_data = $urandom;
         end
         if (!bus.nn_req || nh) begin
            bus.nn_req  = $urandom_range(0, 1) == 1;
            bus.nn_addr = 16'(rnd_addr());
         end
         if ($urandom_range(0, 7) == 0) bus.nn_lock = !bus.nn_lock;
         bus.clear_start = (i == clr_at);
      end
      tick();
      bus.draw_req    = 1'b0;
      bus.nn_req      = 1'b0;
      bus.nn_lock     = 1'b0;
      bus.clear_start = 1'b0;
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog cycle=%0d actual=timeout required=finish", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      bus.clear_start = 1'b0;
      bus.draw_req    = 1'b0;
      bus.draw_addr   = '0;
      bus.draw_data   = '0;
      bus.nn_req      = 1'b0;
      bus.nn_addr     = '0;
      bus.nn_lock     = 1'b0;
      for (int i = 0; i < NPIX; i++) begin
         mem[i]     = $urandom;
         ref_mem[i] = int'(mem[i]);
      end
      repeat (3) tick();
      reset = 1'b0;
      @(negedge CLOCK_50);
      chk("rst_mem_addr", int'(bus.mem_addr), 0);
      chk("rst_mem_wdata", int'(bus.mem_wdata), 0);
      chk("rst_nn_rdata", int'(bus.nn_rdata), 0);
      chk("rst_mem_we", bus.mem_we, 0);

      // Single draw then read it back.
      do_draw(406, 1);
      do_nn(406);
      repeat (4) tick();

      // Four back-to-back reads of addresses 0..3.
      bus.nn_req  = 1'b1;
      bus.nn_addr = 16'd0;
      for (int i = 0; i < 4; i++) begin
         @(negedge CLOCK_50);
         chk("burst_ack", bus.nn_ack, 1);
         tick();
         bus.nn_addr = 16'(i + 1);
      end
      bus.nn_req = 1'b0;
      repeat (4) tick();

      // Both requesters held: alternation, then nn_lock masks draw.
      bus.draw_req  = 1'b1;
      bus.draw_addr = 16'd10;
      bus.draw_data = -32'sd5;
      bus.nn_req    = 1'b1;
      bus.nn_addr   = 16'd11;
      repeat (6) tick();
      bus.nn_lock = 1'b1;
      repeat (4) tick();
      bus.nn_lock = 1'b0;

      // Clear with both requests pending; second clear_start is ignored.
      bus.clear_start = 1'b1;
      tick();
      bus.clear_start = 1'b0;
      repeat (399) tick();
      bus.clear_start = 1'b1;
      tick();
      bus.clear_start = 1'b0;
      repeat (395) tick();
      bus.draw_req = 1'b0;
      bus.nn_req   = 1'b0;
      repeat (4) tick();

      // Out-of-range accesses.
      do_draw(784, 7);
      do_nn(1000);
      repeat (4) tick();

      // Reset during clear write 300, then a fresh clear.
      bus.clear_start = 1'b1;
      tick();
      bus.clear_start = 1'b0;
      repeat (300) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge CLOCK_50);
      chk("rst_mid_clear_we", bus.mem_we, 0);
      chk("rst_mid_clear_busy", bus.busy, 0);
      repeat (5) tick();
      bus.clear_start = 1'b1;
      tick();
      bus.clear_start = 1'b0;
      repeat (790) tick();

      // Random traffic with a clear landing in the middle.
      rand_phase(600, -1);
      rand_phase(1300, 300);
      repeat (10) tick();

      chk("wq_drained", wq.size(), 0);
      chk("rq_drained", rq.size(), 0);
      chk("eq_drained", eq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
